// File: rtl/scroll_display.sv
// Scrolling 8-nibble marquee (opcode, five BCD digits, two blanks) shown four nibbles at a time.
// Optional leading-zero blanking of d4..d1 at capture time: define SCROLL_LZ_BLANK_EN.
module scroll_display #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter logic [3:0]  BLANK    = 4'hF
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [19:0] bcd_in,
   input  logic [1:0]  op,
   input  logic        load,
   input  logic        stop,
   output logic [15:0] dataout,
   output logic        busy,
   output logic        step
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t        state, state_next;
   logic [3:0]    ring [8];
   logic [3:0]    cap  [8];
   logic [2:0]    pos;
   logic [CW-1:0] cnt;
   logic          step_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_next;
   end

   // load outranks stop; stop in IDLE simply stays in IDLE
   always_comb begin
      state_next = state;
      if (load)      state_next = SHOW;
      else if (stop) state_next = IDLE;
   end

   always_comb begin
      busy    = (state == SHOW);
      step    = (state == SHOW) && step_q;
      dataout = {BLANK, BLANK, BLANK, BLANK};
      if (state == SHOW)
         dataout = {ring[pos], ring[pos + 3'd1], ring[pos + 3'd2], ring[pos + 3'd3]};
   end

   // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < 8; i++) cap[i] = BLANK;
      unique case (op)
         2'b00: cap[0] = 4'hA;
         2'b01: cap[0] = 4'hB;
         2'b10: cap[0] = 4'hD;
         2'b11: cap[0] = 4'hC;
      endcase
`ifdef SCROLL_LZ_BLANK_EN
      begin
         logic lead;
         lead = 1'b1;
         for (int i = 4; i >= 1; i--) begin
            if (lead && bcd_in[i*4 +: 4] == 4'd0) begin
               cap[5-i] = BLANK;
            end else begin
               cap[5-i] = bcd_in[i*4 +: 4];
               lead     = 1'b0;
            end
         end
      end
`else
      for (int i = 4; i >= 1; i--) cap[5-i] = bcd_in[i*4 +: 4];
`endif
      cap[5] = bcd_in[3:0];
   end

   // NOTE: the ring is only eight nibbles of flops, so it is reset like any other register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 8; i++) ring[i] <= BLANK;
         pos    <= '0;
         cnt    <= '0;
         step_q <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < 8; i++) ring[i] <= cap[i];
         pos    <= '0;
         cnt    <= '0;
         step_q <= 1'b0;
      end else if (state == SHOW && !stop) begin
         if (cnt == CNT_MAX) begin
            cnt    <= '0;
            pos    <= pos + 3'd1;
            step_q <= 1'b1;
         end else begin
            cnt    <= cnt + CW'(1);
            step_q <= 1'b0;
         end
      end else begin
         step_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scroll_display.sv
// Randomised scoreboard bench for scroll_display; the model tracks cycles since load and derives the window.
module tb_scroll_display;
   localparam int TICK_DIV = 4;
   localparam logic [3:0] BLANK = 4'hF;

   logic        clk = 1'b0;
   logic        clr;
   logic [19:0] bcd_in;
   logic [1:0]  op;
   logic        load, stop;
   logic [15:0] dataout;
   logic        busy, step;

   scroll_display #(.TICK_DIV(TICK_DIV), .BLANK(BLANK)) dut (
      .clk(clk), .clr(clr), .bcd_in(bcd_in), .op(op), .load(load),
      .stop(stop), .dataout(dataout), .busy(busy), .step(step)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] data;
      logic        busy;
      logic        step;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // reference model: message contents plus number of SHOW cycles elapsed since the last load
   logic [3:0] m_ring [8];
   bit         m_show = 0;
   int         m_age  = 0;

   function automatic logic [3:0] opcode(input logic [1:0] o);
      logic [3:0] tbl [4];
      tbl[0] = 4'hA; tbl[1] = 4'hB; tbl[2] = 4'hD; tbl[3] = 4'hC;
      return tbl[o];
   endfunction

   task automatic model_capture(input logic [1:0] o, input logic [19:0] b);
      bit seen_nz;
      m_ring[0] = opcode(o);
      seen_nz = 0;
      for (int k = 1; k <= 5; k++) begin
         logic [3:0] d;
         d = b[(5-k)*4 +: 4];
         if (d != 0 || k == 5) seen_nz = 1;
`ifdef SCROLL_LZ_BLANK_EN
         m_ring[k] = seen_nz ? d : BLANK;
`else
         m_ring[k] = d;
`endif
      end
      m_ring[6] = BLANK;
      m_ring[7] = BLANK;
   endtask

   always @(negedge clr) begin
      m_show = 0;
      m_age  = 0;
   end

   always @(posedge clk) begin
      exp_t e;
      int   p;
      if (clr) begin
         if (load) begin
            model_capture(op, bcd_in);
            m_age  = 0;
            m_show = 1;
         end else if (m_show && stop) begin
            m_show = 0;
         end else if (m_show) begin
            m_age++;
         end
      end
      e.busy = m_show;
      e.step = m_show && m_age > 0 && (m_age % TICK_DIV) == 0;
      e.data = 16'hFFFF;
      if (m_show) begin
         p = (m_age / TICK_DIV) % 8;
         for (int k = 0; k < 4; k++) e.data[15-4*k -: 4] = m_ring[(p + k) % 8];
      end
      sb.push_back(e);
   end

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         pops++;
         check("dataout", dataout, e.data);
         check("busy", {15'd0, busy}, {15'd0, e.busy});
         check("step", {15'd0, step}, {15'd0, e.step});
      end
   end

   task automatic cyc(input logic ld, input logic st, input logic [1:0] o, input logic [19:0] b);
      load   = ld;
      stop   = st;
      op     = o;
      bcd_in = b;
      @(negedge clk);
   endtask

   function automatic logic [19:0] rand_bcd();
      logic [19:0] b;
      for (int k = 0; k < 5; k++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r < 4)       b[k*4 +: 4] = 4'd0;
         else if (r < 11) b[k*4 +: 4] = 4'($urandom_range(1, 9));
         else             b[k*4 +: 4] = 4'($urandom_range(10, 15));
      end
      return b;
   endfunction

   initial begin
      clr = 1'b0; load = 1'b0; stop = 1'b0; op = 2'b00; bcd_in = '0;
      #1;
      check("reset_dataout", dataout, 16'hFFFF);
      check("reset_busy", {15'd0, busy}, 16'd0);
      @(negedge clk); @(negedge clk);
      clr = 1'b1;
      repeat (3) cyc(0, 0, 2'($urandom), 20'($urandom));

      // full lap including wrap, with unsampled input churn
      cyc(1, 0, 2'b00, 20'h00123);
      repeat (36) cyc(0, 0, 2'($urandom), 20'($urandom));

      // reload while scrolling at pos 5
      cyc(1, 0, 2'b01, 20'h90807);
      repeat (20) cyc(0, 0, 2'b00, '0);
      cyc(1, 0, 2'b11, 20'h00225);
      repeat (10) cyc(0, 0, 2'b00, '0);

      // load+stop together, then stop alone, then stop in IDLE
      cyc(1, 1, 2'b10, 20'h0A0F3);
      repeat (6) cyc(0, 0, 2'b00, '0);
      cyc(0, 1, 2'b00, '0);
      repeat (3) cyc(0, 0, 2'b00, '0);
      cyc(0, 1, 2'b00, '0);
      repeat (2) cyc(0, 0, 2'b00, '0);

      // asynchronous reset mid-count at pos 3
      cyc(1, 0, 2'b00, 20'h54321);
      repeat (13) cyc(0, 0, 2'b00, '0);
      #1 clr = 1'b0;
      #1;
      check("async_dataout", dataout, 16'hFFFF);
      check("async_busy", {15'd0, busy}, 16'd0);
      @(negedge clk); @(negedge clk);
      clr = 1'b1;
      repeat (8) cyc(0, 0, 2'b00, '0);

      for (int i = 0; i < 1500; i++) begin
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
             2'($urandom), rand_bcd());
      end
      cyc(0, 0, 2'b00, '0);
      @(negedge clk);
      check("monitor_ran", {15'd0, pops > 1000}, 16'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
